// File: rtl/ni_pkg.sv
// ni_pkg
// Shared definitions for the parametrised GPU network interface (ni_param).
// Holds:
//   - Default widths and sizes for the NI parameters.
//   - egress_route_e, which says where an incoming GPU word goes.
//   - id_to_addr / addr_to_id: arithmetic translation between a GPU ID and
//     its routing address, offset by a fixed amount. No lookup table is used.
//   - id_is_valid: checks that a GPU ID lies in [1, max_id].
//   - is_pow2: helper for the FIFO depth check at elaboration.
package ni_pkg;

  localparam int unsigned DEF_GPU_ID      = 7;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ID_W        = 6;
  localparam int unsigned DEF_ADDR_OFFSET = 3;
  localparam int unsigned DEF_MAX_ID      = 32;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    EG_ROUTER = 2'd0,
    EG_LOOP   = 2'd1,
    EG_DROP   = 2'd2
  } egress_route_e;

  function automatic int unsigned id_to_addr(input int unsigned id,
                                             input int unsigned offset);
    return id + offset;
  endfunction

  function automatic int unsigned addr_to_id(input int unsigned addr,
                                             input int unsigned offset);
    return addr - offset;
  endfunction

  function automatic logic id_is_valid(input int unsigned id,
                                       input int unsigned max_id);
    return (id >= 1) && (id <= max_id);
  endfunction

  function automatic logic is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ni_param_if.sv
// ni_param_if
// Groups the four valid/ready streams of the NI into one bundle.
//   gpu_*_in     : GPU -> NI words (egress source)
//   gpu_*_out    : NI -> GPU words (ingress sink)
//   router_*_out : NI -> router words (egress sink)
//   router_*_in  : router -> NI words (ingress source)
// Modports:
//   slave  : the NI's view of the bundle.
//   master : the surrounding environment's view, which covers the GPU and
//            the router together.
interface ni_param_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] gpu_data_in;
  logic              gpu_valid_in;
  logic              gpu_ready_out;

  logic [DATA_W-1:0] gpu_data_out;
  logic              gpu_valid_out;
  logic              gpu_ready_in;

  logic [DATA_W-1:0] router_data_out;
  logic              router_valid_out;
  logic              router_ready_in;

  logic [DATA_W-1:0] router_data_in;
  logic              router_valid_in;
  logic              router_ready_out;

  modport slave (
    input  gpu_data_in, gpu_valid_in,
    output gpu_ready_out,
    output gpu_data_out, gpu_valid_out,
    input  gpu_ready_in,
    output router_data_out, router_valid_out,
    input  router_ready_in,
    input  router_data_in, router_valid_in,
    output router_ready_out
  );

  modport master (
    output gpu_data_in, gpu_valid_in,
    input  gpu_ready_out,
    input  gpu_data_out, gpu_valid_out,
    output gpu_ready_in,
    input  router_data_out, router_valid_out,
    output router_ready_in,
    output router_data_in, router_valid_in,
    input  router_ready_out
  );

endinterface

// File: rtl/ni_fifo.sv
// ni_fifo
// Synchronous FIFO with a power-of-two depth. The head word is read
// combinationally, so it is visible on dout as soon as it has been written.
// Ports:
//   clk, reset : clock and asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : current head word
//   full/empty : occupancy flags
//   count      : number of stored words, 0..DEPTH
module ni_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Both pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_param.sv
// ni_param
// Parametrised GPU network interface. It sits between one GPU port and its
// leaf router.
//
// Egress path (GPU to router):
//   - The header of each word is the destination GPU ID.
//   - Valid IDs are rewritten to their routing address, ID + ADDR_OFFSET,
//     and queued in the g2r FIFO.
//   - Invalid IDs are accepted, discarded and counted.
//
// Ingress path (router to GPU):
//   - Words addressed to this node have their header rewritten back to
//     GPU_ID and are queued in the r2g FIFO.
//   - All other words are discarded and counted.
//
// Both directions end in a registered output stage.
//
// Optional feature, selected by the macro NI_LOOPBACK_EN:
//   A GPU word addressed to GPU_ID is written straight into the r2g FIFO
//   and never reaches the router. The router keeps priority on the r2g
//   write port.
//
// Ports:
//   clk, reset  : clock and asynchronous active-low reset
//   bus         : ni_param_if.slave, carrying all four valid/ready streams
//   drop_clr    : synchronous clear of drop_count
//   drop_count  : saturating count of dropped words
module ni_param
  import ni_pkg::*;
#(
  parameter int unsigned GPU_ID      = DEF_GPU_ID,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ID_W        = DEF_ID_W,
  parameter int unsigned ADDR_OFFSET = DEF_ADDR_OFFSET,
  parameter int unsigned MAX_ID      = DEF_MAX_ID,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  ni_param_if.slave        bus,
  input  logic             drop_clr,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned PAY_W = DATA_W - ID_W;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ID_W-1:0] OWN_ID   = ID_W'(GPU_ID);
  localparam logic [ID_W-1:0] OWN_ADDR = ID_W'(id_to_addr(GPU_ID, ADDR_OFFSET));

  // Reject configurations whose addresses would not fit in the header.
  if (MAX_ID + ADDR_OFFSET >= (1 << ID_W)) begin : g_chk_addr_overflow
    $error("ni_param: MAX_ID + ADDR_OFFSET does not fit in ID_W bits");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_chk_depth
    $error("ni_param: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (ID_W >= DATA_W) begin : g_chk_id_w
    $error("ni_param: ID_W must be narrower than DATA_W");
  end
  if (!id_is_valid(GPU_ID, MAX_ID)) begin : g_chk_gpu_id
    $error("ni_param: GPU_ID must lie in 1..MAX_ID");
  end

  logic [ID_W-1:0]   gpu_hdr;
  logic [PAY_W-1:0]  gpu_pay;
  logic [ID_W-1:0]   rtr_hdr;
  logic [PAY_W-1:0]  rtr_pay;

  egress_route_e     eg_route;
  logic              gpu_self;
  logic              gpu_ready;
  logic              rtr_ready;
  logic              gpu_fire;
  logic              rtr_fire;
  logic              rtr_match;
  logic              eg_drop;
  logic              ig_drop;
  logic              loop_push;
  logic              rtr_push;

  logic              g2r_push;
  logic              g2r_pop;
  logic [DATA_W-1:0] g2r_din;
  logic [DATA_W-1:0] g2r_dout;
  logic              g2r_full;
  logic              g2r_empty;
  logic [CW-1:0]     g2r_count_unused;

  logic              r2g_push;
  logic              r2g_pop;
  logic [DATA_W-1:0] r2g_din;
  logic [DATA_W-1:0] r2g_dout;
  logic              r2g_full;
  logic              r2g_empty;
  logic [CW-1:0]     r2g_count_unused;

  logic [DATA_W-1:0] router_data_q;
  logic              router_valid_q;
  logic [DATA_W-1:0] gpu_data_q;
  logic              gpu_valid_q;

  logic [1:0]        drop_inc;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  drop_q;

  assign gpu_hdr = bus.gpu_data_in[DATA_W-1 -: ID_W];
  assign gpu_pay = bus.gpu_data_in[PAY_W-1:0];
  assign rtr_hdr = bus.router_data_in[DATA_W-1 -: ID_W];
  assign rtr_pay = bus.router_data_in[PAY_W-1:0];

`ifdef NI_LOOPBACK_EN
  assign gpu_self = (gpu_hdr == OWN_ID);
`else
  assign gpu_self = 1'b0;
`endif

  // Classify the GPU word. Invalid IDs are dropped first, then a
  // self-addressed word takes the loopback path when it is enabled.
  always_comb begin
    eg_route = EG_ROUTER;
    if (!id_is_valid(32'(gpu_hdr), MAX_ID)) begin
      eg_route = EG_DROP;
    end else if (gpu_self) begin
      eg_route = EG_LOOP;
    end
  end

  // Words that will be dropped are always accepted, whatever the FIFO state.
  // Loopback words also wait while the router is writing r2g this cycle.
  always_comb begin
    gpu_ready = 1'b0;
    case (eg_route)
      EG_DROP: gpu_ready = 1'b1;
      EG_LOOP: gpu_ready = !r2g_full && !(bus.router_valid_in && rtr_ready);
      default: gpu_ready = !g2r_full;
    endcase
  end

  assign rtr_ready            = !r2g_full;
  assign bus.gpu_ready_out    = gpu_ready;
  assign bus.router_ready_out = rtr_ready;

  assign gpu_fire  = bus.gpu_valid_in & gpu_ready;
  assign rtr_fire  = bus.router_valid_in & rtr_ready;
  assign rtr_match = (rtr_hdr == OWN_ADDR);

  assign g2r_push  = gpu_fire && (eg_route == EG_ROUTER);
  assign loop_push = gpu_fire && (eg_route == EG_LOOP);
  assign eg_drop   = gpu_fire && (eg_route == EG_DROP);
  assign rtr_push  = rtr_fire & rtr_match;
  assign ig_drop   = rtr_fire & ~rtr_match;

  assign g2r_din = {ID_W'(id_to_addr(32'(gpu_hdr), ADDR_OFFSET)), gpu_pay};

  // The router and loopback never write r2g in the same cycle, because the
  // GPU is stalled then. Router words get their header rewritten; loopback
  // words already carry GPU_ID.
  assign r2g_push = rtr_push | loop_push;
  assign r2g_din  = rtr_push
                  ? {ID_W'(addr_to_id(32'(rtr_hdr), ADDR_OFFSET)), rtr_pay}
                  : bus.gpu_data_in;

  ni_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_g2r_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (g2r_push),
    .din   (g2r_din),
    .pop   (g2r_pop),
    .dout  (g2r_dout),
    .full  (g2r_full),
    .empty (g2r_empty),
    .count (g2r_count_unused)
  );

  ni_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_r2g_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r2g_push),
    .din   (r2g_din),
    .pop   (r2g_pop),
    .dout  (r2g_dout),
    .full  (r2g_full),
    .empty (r2g_empty),
    .count (r2g_count_unused)
  );

  // An output register reloads when it is empty or its word is being taken.
  // Otherwise it holds its word stable.
  assign g2r_pop = (!router_valid_q || bus.router_ready_in) && !g2r_empty;
  assign r2g_pop = (!gpu_valid_q || bus.gpu_ready_in) && !r2g_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      router_valid_q <= 1'b0;
      router_data_q  <= '0;
    end else if (!router_valid_q || bus.router_ready_in) begin
      router_valid_q <= !g2r_empty;
      if (!g2r_empty) router_data_q <= g2r_dout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpu_valid_q <= 1'b0;
      gpu_data_q  <= '0;
    end else if (!gpu_valid_q || bus.gpu_ready_in) begin
      gpu_valid_q <= !r2g_empty;
      if (!r2g_empty) gpu_data_q <= r2g_dout;
    end
  end

  assign bus.router_data_out  = router_data_q;
  assign bus.router_valid_out = router_valid_q;
  assign bus.gpu_data_out     = gpu_data_q;
  assign bus.gpu_valid_out    = gpu_valid_q;

  // The extra sum bit catches overflow, so the count can saturate at all ones.
  assign drop_inc = {1'b0, eg_drop} + {1'b0, ig_drop};
  assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (drop_clr) begin
      drop_q <= '0;
    end else if (drop_sum[CNT_W]) begin
      drop_q <= '1;
    end else begin
      drop_q <= drop_sum[CNT_W-1:0];
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_ni_param.sv
// tb_ni_param
// Directed testbench for ni_param with GPU_ID=7, ADDR_OFFSET=3 and
// MAX_ID=32, so this node's routing address is 10. The 2-bit drop counter
// exposes saturation. The self-addressed test follows NI_LOOPBACK_EN.
module tb_ni_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       drop_clr;
  logic [1:0] drop_count;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  ni_param_if #(.DATA_W(16)) bus ();

  ni_param #(.CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_clr   (drop_clr),
    .drop_count (drop_count)
  );

  function automatic logic [15:0] mk_word(input logic [5:0] id, input logic [9:0] pay);
    return {id, pay};
  endfunction

  task automatic idle_inputs();
    bus.gpu_data_in     = 16'h0000;
    bus.gpu_valid_in    = 1'b0;
    bus.gpu_ready_in    = 1'b1;
    bus.router_data_in  = 16'h0000;
    bus.router_valid_in = 1'b0;
    bus.router_ready_in = 1'b1;
    drop_clr            = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.gpu_data_in = 16'h2C05;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.gpu_data_out !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_gpu_data: got %h want 0000", bus.gpu_data_out); end
    compared++; if (bus.gpu_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gpu_valid: got %b want 0", bus.gpu_valid_out); end
    compared++; if (bus.router_data_out !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_router_data: got %h want 0000", bus.router_data_out); end
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_router_valid: got %b want 0", bus.router_valid_out); end
    compared++; if (drop_count !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_drop_count: got %0d want 0", drop_count); end
    compared++; if (bus.gpu_ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_gpu_ready: got %b want 1", bus.gpu_ready_out); end
    compared++; if (bus.router_ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_router_ready: got %b want 1", bus.router_ready_out); end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_egress();
    bus.gpu_data_in  = 16'h2C05;
    bus.gpu_valid_in = 1'b1;
    step();
    bus.gpu_valid_in = 1'b0;
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL egress_early: got valid %b want 0", bus.router_valid_out); end
    step();
    compared++; if (bus.router_valid_out !== 1'b1 || bus.router_data_out !== 16'h3805) begin mismatched++; $display("[TB] FAIL egress_word: got valid %b data %h want 1/3805", bus.router_valid_out, bus.router_data_out); end
    step();
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL egress_one_cycle: got valid %b want 0", bus.router_valid_out); end
  endtask

  task automatic test_backpressure();
    logic [5:0] ids [10] = '{6'd1, 6'd2, 6'd5, 6'd9, 6'd11, 6'd20, 6'd28, 6'd31, 6'd32, 6'd4};
    int   accepted = 0;
    logic rdy = 1'b0;
    bus.router_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.gpu_data_in  = mk_word(ids[i], 10'(i * 7));
      bus.gpu_valid_in = 1'b1;
      #1;
      rdy = bus.gpu_ready_out;
      step();
      if (rdy) accepted++;
    end
    bus.gpu_valid_in = 1'b0;
    compared++; if (accepted !== 9) begin mismatched++; $display("[TB] FAIL bp_accepted: got %0d want 9", accepted); end
    compared++; if (rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_tenth_ready: got %b want 0", rdy); end
    step();
    step();
    compared++; if (bus.gpu_ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_held: got %b want 0", bus.gpu_ready_out); end
    bus.router_ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      compared++;
      if (bus.router_valid_out !== 1'b1 || bus.router_data_out !== mk_word(ids[i] + 6'd3, 10'(i * 7))) begin
        mismatched++;
        $display("[TB] FAIL bp_drain_%0d: got valid %b data %h want 1/%h", i, bus.router_valid_out, bus.router_data_out, mk_word(ids[i] + 6'd3, 10'(i * 7)));
      end
      step();
    end
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain_end: got valid %b want 0", bus.router_valid_out); end
  endtask

  task automatic test_ingress();
    bus.router_data_in  = 16'h2801;
    bus.router_valid_in = 1'b1;
    step();
    bus.router_data_in = 16'h3001;
    step();
    bus.router_valid_in = 1'b0;
    compared++; if (bus.gpu_valid_out !== 1'b1 || bus.gpu_data_out !== 16'h1C01) begin mismatched++; $display("[TB] FAIL ingress_word: got valid %b data %h want 1/1C01", bus.gpu_valid_out, bus.gpu_data_out); end
    compared++; if (drop_count !== 2'd1) begin mismatched++; $display("[TB] FAIL ingress_drop_count: got %0d want 1", drop_count); end
    step();
    compared++; if (bus.gpu_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL ingress_discarded: got valid %b want 0", bus.gpu_valid_out); end
  endtask

  task automatic test_drops();
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    compared++; if (drop_count !== 2'd0) begin mismatched++; $display("[TB] FAIL drop_clr_initial: got %0d want 0", drop_count); end
    bus.gpu_data_in     = 16'h0001;
    bus.gpu_valid_in    = 1'b1;
    bus.router_data_in  = 16'h3001;
    bus.router_valid_in = 1'b1;
    #1;
    compared++; if (bus.gpu_ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_gpu_ready: got %b want 1", bus.gpu_ready_out); end
    step();
    compared++; if (drop_count !== 2'd2) begin mismatched++; $display("[TB] FAIL drop_double: got %0d want 2", drop_count); end
    bus.router_valid_in = 1'b0;
    bus.gpu_data_in     = 16'h8400;
    step();
    compared++; if (drop_count !== 2'd3) begin mismatched++; $display("[TB] FAIL drop_id_above_max: got %0d want 3", drop_count); end
    bus.gpu_data_in     = 16'h0001;
    bus.router_valid_in = 1'b1;
    step();
    compared++; if (drop_count !== 2'd3) begin mismatched++; $display("[TB] FAIL drop_saturate: got %0d want 3", drop_count); end
    drop_clr = 1'b1;
    step();
    compared++; if (drop_count !== 2'd0) begin mismatched++; $display("[TB] FAIL drop_clr_override: got %0d want 0", drop_count); end
    idle_inputs();
    step();
    compared++; if (drop_count !== 2'd0) begin mismatched++; $display("[TB] FAIL drop_after_clr: got %0d want 0", drop_count); end
    compared++; if (bus.router_valid_out !== 1'b0 || bus.gpu_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_not_forwarded: got router %b gpu %b want 0/0", bus.router_valid_out, bus.gpu_valid_out); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    bus.router_ready_in = 1'b0;
    bus.gpu_ready_in    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.gpu_data_in     = mk_word(6'(2 + i), 10'(i));
      bus.gpu_valid_in    = 1'b1;
      bus.router_data_in  = mk_word(6'd10, 10'(16 + i));
      bus.router_valid_in = 1'b1;
      step();
    end
    bus.gpu_valid_in    = 1'b0;
    bus.router_valid_in = 1'b0;
    step();
    compared++; if (bus.router_valid_out !== 1'b1 || bus.gpu_valid_out !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_pre: got router %b gpu %b want 1/1", bus.router_valid_out, bus.gpu_valid_out); end
    reset = 1'b0;
    #1;
    compared++; if (bus.router_valid_out !== 1'b0 || bus.router_data_out !== 16'h0) begin mismatched++; $display("[TB] FAIL midreset_router: got valid %b data %h want 0/0000", bus.router_valid_out, bus.router_data_out); end
    compared++; if (bus.gpu_valid_out !== 1'b0 || bus.gpu_data_out !== 16'h0) begin mismatched++; $display("[TB] FAIL midreset_gpu: got valid %b data %h want 0/0000", bus.gpu_valid_out, bus.gpu_data_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.router_valid_out || bus.gpu_valid_out) stale++;
    end
    compared++; if (stale !== 0) begin mismatched++; $display("[TB] FAIL midreset_stale: got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_self_addressed();
    bus.gpu_data_in  = 16'h1C0A;
    bus.gpu_valid_in = 1'b1;
    step();
    bus.gpu_valid_in = 1'b0;
    step();
`ifdef NI_LOOPBACK_EN
    compared++; if (bus.gpu_valid_out !== 1'b1 || bus.gpu_data_out !== 16'h1C0A) begin mismatched++; $display("[TB] FAIL loop_word: got valid %b data %h want 1/1C0A", bus.gpu_valid_out, bus.gpu_data_out); end
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL loop_not_routed: got %b want 0", bus.router_valid_out); end
    bus.router_data_in  = 16'h2802;
    bus.router_valid_in = 1'b1;
    bus.gpu_data_in     = 16'h1C0B;
    bus.gpu_valid_in    = 1'b1;
    #1;
    compared++; if (bus.gpu_ready_out !== 1'b0) begin mismatched++; $display("[TB] FAIL loop_stall: got ready %b want 0", bus.gpu_ready_out); end
    step();
    bus.router_valid_in = 1'b0;
    compared++; if (bus.gpu_ready_out !== 1'b1) begin mismatched++; $display("[TB] FAIL loop_resume: got ready %b want 1", bus.gpu_ready_out); end
    step();
    bus.gpu_valid_in = 1'b0;
    compared++; if (bus.gpu_valid_out !== 1'b1 || bus.gpu_data_out !== 16'h1C02) begin mismatched++; $display("[TB] FAIL loop_router_first: got valid %b data %h want 1/1C02", bus.gpu_valid_out, bus.gpu_data_out); end
    step();
    compared++; if (bus.gpu_valid_out !== 1'b1 || bus.gpu_data_out !== 16'h1C0B) begin mismatched++; $display("[TB] FAIL loop_gpu_second: got valid %b data %h want 1/1C0B", bus.gpu_valid_out, bus.gpu_data_out); end
    step();
    compared++; if (bus.router_valid_out !== 1'b0 || bus.gpu_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL loop_idle: got router %b gpu %b want 0/0", bus.router_valid_out, bus.gpu_valid_out); end
`else
    compared++; if (bus.router_valid_out !== 1'b1 || bus.router_data_out !== 16'h280A) begin mismatched++; $display("[TB] FAIL self_routed: got valid %b data %h want 1/280A", bus.router_valid_out, bus.router_data_out); end
    compared++; if (bus.gpu_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL self_no_loop: got %b want 0", bus.gpu_valid_out); end
    step();
    compared++; if (bus.router_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL self_one_cycle: got %b want 0", bus.router_valid_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_egress();
    test_backpressure();
    test_ingress();
    test_drops();
    test_reset_midflight();
    test_self_addressed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
